// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Data memory with RV32 load/store unit. Handles byte, half and
//            word accesses (signed and unsigned loads) with per-byte write
//            lanes. A configurable number of wait states sits between accept
//            and response, behind a req/ready/done handshake.
// Ports    : clk, rst_n (async, active low)
//            req, we, funct3[2:0], a[31:0], wd[31:0] : request side
//            ready  : idle, a request is accepted this cycle if req=1
//            done   : one-cycle response pulse
//            rd     : load result (0 after a store or a fault), held
//            err    : qualifies done, the access faulted
// Config   : DMEM_LSU_ERR_EN enables the misalignment, illegal-funct3 and
//            out-of-range checks. Without it, addresses are forced aligned,
//            the word index wraps modulo DEPTH, illegal codes act as W and
//            err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        ready,
    output logic        done,
    output logic [31:0] rd,
    output logic        err
);

    localparam int         c_AW     = $clog2(DEPTH);
    localparam logic [3:0] c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [3:0]      r_cnt;

    // Decoded request held through the wait states.
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [1:0]      r_off;
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_wd;
    logic            r_fault;

    logic [31:0]     r_rd;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    // Live decode of the request on the input pins.
    logic [1:0]      w_size;
    logic            w_uns;
    logic            w_illegal;
    logic [1:0]      w_off;
    logic [c_AW-1:0] w_idx;
    logic            w_fault;

    // Operation executed on the commit edge: live decode when committing
    // straight out of IDLE, otherwise the registered copy.
    logic            w_sel_we;
    logic [1:0]      w_sel_size;
    logic            w_sel_uns;
    logic [1:0]      w_sel_off;
    logic [c_AW-1:0] w_sel_idx;
    logic [31:0]     w_sel_wd;
    logic            w_sel_fault;

    logic            w_accept;
    logic            w_commit;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_word;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_size    = c_SZ_W;
        w_uns     = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            3'b000: w_size = c_SZ_B;
            3'b001: w_size = c_SZ_H;
            3'b010: w_size = c_SZ_W;
            3'b100: begin w_size = c_SZ_B; w_uns = 1'b1; w_illegal = we; end
            3'b101: begin w_size = c_SZ_H; w_uns = 1'b1; w_illegal = we; end
            default: w_illegal = 1'b1;
        endcase
        // Illegal codes degrade to a plain word access when unchecked.
        if (w_illegal) begin
            w_size = c_SZ_W;
            w_uns  = 1'b0;
        end
    end

    // Byte offset within the word; low bits below the access size dropped.
    always_comb begin
        case (w_size)
            c_SZ_B:  w_off = a[1:0];
            c_SZ_H:  w_off = {a[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_idx = a[c_AW+1:2];

`ifdef DMEM_LSU_ERR_EN
    logic w_misalign;
    logic w_range;
    assign w_misalign = ((w_size == c_SZ_H) && a[0]) ||
                        ((w_size == c_SZ_W) && (a[1:0] != 2'b00));
    assign w_range    = (a[31:c_AW+2] != '0);
    assign w_fault    = w_illegal || w_misalign || w_range;
`else
    logic w_unused_hi;
    assign w_unused_hi = ^a[31:c_AW+2];
    assign w_fault     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (req) w_state_nxt = (LATENCY > 0) ? c_WAIT : c_RESP;
            c_WAIT:  if (r_cnt == 4'd0) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign w_accept = (r_state == c_IDLE) && req;
    // RESP is only ever entered from IDLE or WAIT, so this is the commit edge.
    assign w_commit = (w_state_nxt == c_RESP);

    always_comb begin
        if (r_state == c_IDLE) begin
            w_sel_we    = we;
            w_sel_size  = w_size;
            w_sel_uns   = w_uns;
            w_sel_off   = w_off;
            w_sel_idx   = w_idx;
            w_sel_wd    = wd;
            w_sel_fault = w_fault;
        end else begin
            w_sel_we    = r_we;
            w_sel_size  = r_size;
            w_sel_uns   = r_uns;
            w_sel_off   = r_off;
            w_sel_idx   = r_idx;
            w_sel_wd    = r_wd;
            w_sel_fault = r_fault;
        end
    end

    // ------------------------------------------------------------------
    // Store lanes and load extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_sel_wd;
        case (w_sel_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << w_sel_off;
                w_wdata = {4{w_sel_wd[7:0]}};
            end
            c_SZ_H: begin
                w_be    = 4'b0011 << w_sel_off;
                w_wdata = {2{w_sel_wd[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = w_sel_wd;
            end
        endcase
    end

    assign w_word    = r_mem[w_sel_idx];
    assign w_shifted = w_word >> {w_sel_off, 3'b000};

    always_comb begin
        case (w_sel_size)
            c_SZ_B:  w_load = w_sel_uns ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_H:  w_load = w_sel_uns ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // RAM has no reset. The write is gated by rst_n so a request seen while
    // reset is held can never commit.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_sel_we && !w_sel_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_sel_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= c_SZ_W;
            r_uns   <= 1'b0;
            r_off   <= 2'b00;
            r_idx   <= '0;
            r_wd    <= 32'h0;
            r_fault <= 1'b0;
            r_rd    <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= we;
                r_size  <= w_size;
                r_uns   <= w_uns;
                r_off   <= w_off;
                r_idx   <= w_idx;
                r_wd    <= wd;
                r_fault <= w_fault;
                r_cnt   <= c_LAT_M1;
            end else if ((r_state == c_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rd  <= (w_sel_fault || w_sel_we) ? 32'h0 : w_load;
                r_err <= w_sel_fault;
            end
        end
    end

    assign ready = (r_state == c_IDLE);
    assign done  = (r_state == c_RESP);
    assign err   = done && r_err;
    assign rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Self-checking bench for dmem_lsu. Two instances (LATENCY 0 and
//            LATENCY 3, DEPTH 64) are checked against a byte-array reference
//            model with directed and random load/store traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req    [2];
    logic        we     [2];
    logic [2:0]  f3     [2];
    logic [31:0] a      [2];
    logic [31:0] wd     [2];
    logic        ready  [2];
    logic        done   [2];
    logic [31:0] rd     [2];
    logic        err    [2];

    int          checks = 0;
    int          errors = 0;
    int          lat    [2] = '{0, 3};
    bit   [7:0]  mm     [2][256];

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .funct3(f3[0]),
        .a(a[0]), .wd(wd[0]), .ready(ready[0]), .done(done[0]), .rd(rd[0]),
        .err(err[0])
    );

    dmem_lsu #(.DEPTH(64), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .funct3(f3[1]),
        .a(a[1]), .wd(wd[1]), .ready(ready[1]), .done(done[1]), .rd(rd[1]),
        .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed memory, rules applied directly.
    task automatic model(input int d, input bit w, input bit [2:0] f, input bit [31:0] ad,
                         input bit [31:0] dat, output bit [31:0] erd, output bit eerr);
        int      sz;
        int      base;
        bit      illegal;
        bit      sgn;
        bit [31:0] v;
        illegal = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && (f == 3'd4 || f == 3'd5));
        case (f[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            default: sz = 4;
        endcase
        sgn  = (f[2] == 1'b0);
        eerr = 1'b0;
        erd  = 32'h0;
`ifdef DMEM_LSU_ERR_EN
        if (illegal || (ad % sz) != 0 || (ad / 4) >= 64) begin
            eerr = 1'b1;
            return;
        end
`else
        if (illegal) sz = 4;
`endif
        base = int'(((ad / 4) % 64) * 4 + ((ad % 4) / sz) * sz);
        if (w) begin
            for (int i = 0; i < sz; i++) mm[d][base+i] = dat[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(mm[d][base+i]) << (8*i));
            if (sgn && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            erd = v;
        end
    endtask

    task automatic access(input int d, input bit w, input bit [2:0] f, input logic [31:0] ad,
                          input logic [31:0] dat, input string tag,
                          output logic [31:0] got, output logic gerr);
        bit [31:0] erd;
        bit        eerr;
        int        cyc;
        model(d, w, f, ad, dat, erd, eerr);
        @(negedge clk);
        check({tag, ":ready"}, {31'h0, ready[d]}, 32'd1);
        req[d] = 1'b1; we[d] = w; f3[d] = f; a[d] = ad; wd[d] = dat;
        @(negedge clk);
        req[d] = 1'b0;
        cyc = 1;
        while (done[d] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ":latency"}, 32'(cyc), 32'(lat[d] + 1));
        check({tag, ":err"}, {31'h0, err[d]}, {31'h0, eerr});
        check({tag, ":rd"}, rd[d], erd);
        got  = rd[d];
        gerr = err[d];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [31:0] ad;
        bit   [2:0]  f;
        bit          w;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'b010; a[d] = 32'h0; wd[d] = 32'h0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset:ready", {31'h0, ready[d]}, 32'd1);
            check("reset:done",  {31'h0, done[d]},  32'd0);
            check("reset:err",   {31'h0, err[d]},   32'd0);
            check("reset:rd",    rd[d],             32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill both memories so the model is fully known.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                access(d, 1'b1, 3'b010, 32'(i * 4), $urandom, "init", got, gerr);

        // Sub-word loads and stores.
        for (int d = 0; d < 2; d++) begin
            access(d, 1, 3'b010, 32'h10, 32'h8899AABB, "sw10", got, gerr);
            access(d, 0, 3'b000, 32'h13, 32'h0, "lb13", got, gerr);
            check("lb13:lit", got, 32'hFFFFFF88);
            access(d, 0, 3'b100, 32'h13, 32'h0, "lbu13", got, gerr);
            check("lbu13:lit", got, 32'h00000088);
            access(d, 0, 3'b001, 32'h12, 32'h0, "lh12", got, gerr);
            check("lh12:lit", got, 32'hFFFF8899);
            access(d, 0, 3'b101, 32'h10, 32'h0, "lhu10", got, gerr);
            check("lhu10:lit", got, 32'h0000AABB);
            access(d, 1, 3'b000, 32'h11, 32'h55, "sb11", got, gerr);
            access(d, 0, 3'b010, 32'h10, 32'h0, "lw10a", got, gerr);
            check("lw10a:lit", got, 32'h889955BB);
            access(d, 1, 3'b001, 32'h12, 32'h1234, "sh12", got, gerr);
            access(d, 0, 3'b010, 32'h10, 32'h0, "lw10b", got, gerr);
            check("lw10b:lit", got, 32'h123455BB);
        end

        // Latency 3 with req held through WAIT: single accept, single done.
        access(1, 1, 3'b010, 32'h40, 32'hDEADBEEF, "sw40", got, gerr);
        @(negedge clk);
        check("hold:ready0", {31'h0, ready[1]}, 32'd1);
        req[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; a[1] = 32'h40;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("hold:ready_low", {31'h0, ready[1]}, 32'd0);
            check("hold:done", {31'h0, done[1]}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                check("hold:rd", rd[1], 32'hDEADBEEF);
                req[1] = 1'b0;
            end
        end
        @(negedge clk);
        check("hold:ready_back", {31'h0, ready[1]}, 32'd1);
        check("hold:no_second", {31'h0, done[1]}, 32'd0);

        // Reset during WAIT of a store: store dropped, outputs cleared.
        access(1, 1, 3'b010, 32'h44, 32'h0BADF00D, "sw44", got, gerr);
        access(1, 0, 3'b010, 32'h40, 32'h0, "lw40", got, gerr);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'b010; a[1] = 32'h44; wd[1] = 32'h11223344;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst:ready", {31'h0, ready[1]}, 32'd1);
        check("rst:done",  {31'h0, done[1]},  32'd0);
        check("rst:err",   {31'h0, err[1]},   32'd0);
        check("rst:rd",    rd[1],             32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst:ready_after", {31'h0, ready[1]}, 32'd1);
        access(1, 0, 3'b010, 32'h44, 32'h0, "rst:lw44", got, gerr);
        check("rst:lw44_lit", got, 32'h0BADF00D);

`ifdef DMEM_LSU_ERR_EN
        access(0, 0, 3'b010, 32'h02, 32'h0, "err:lw02", got, gerr);
        check("err:lw02_err", {31'h0, gerr}, 32'd1);
        access(0, 1, 3'b010, 32'd256, 32'hFFFFFFFF, "err:sw256", got, gerr);
        check("err:sw256_err", {31'h0, gerr}, 32'd1);
        access(0, 0, 3'b011, 32'h10, 32'h0, "err:f3_011", got, gerr);
        check("err:f3_011_err", {31'h0, gerr}, 32'd1);
`else
        access(0, 1, 3'b010, 32'h101, 32'hCAFEF00D, "wrap:sw101", got, gerr);
        access(0, 0, 3'b010, 32'h0, 32'h0, "wrap:lw0", got, gerr);
        check("wrap:lw0_lit", got, 32'hCAFEF00D);
        check("wrap:lw0_err", {31'h0, gerr}, 32'd0);
`endif

        // Random traffic.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                w  = 1'($urandom_range(0, 1));
                f  = 3'($urandom_range(0, 7));
                ad = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
                access(d, w, f, ad, $urandom, "rand", got, gerr);
            end
        end

        // Full readback catches stray or missing writes.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                access(d, 1'b0, 3'b010, 32'(i * 4), 32'h0, "readback", got, gerr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised successor to the single-cycle word data memory. Adds RV32 sub-word loads and stores (byte/half/word, signed and unsigned), per-byte write lanes and a configurable wait-state latency behind a request/ready/done handshake. It also detects misaligned and out-of-range accesses. The block sits between the core's load/store path and on-chip data RAM, and serves as the data memory for the multi-cycle and pipelined cores.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..65536.
- LATENCY, 0, wait-state cycles inserted between accept and response; 0..15.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 1, request valid; sampled only while ready=1.
- we, input, 1, 1 = store, 0 = load.
- funct3, input, 3, RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- a, input, 32, byte address.
- wd, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
- ready, output, 1, block idle and accepting a request.
- done, output, 1, one-cycle pulse: response valid.
- rd, output, 32, load result, sign- or zero-extended; held until the next response.
- err, output, 1, qualifies done; the access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP. After reset the FSM is in IDLE.
- ready is 1 only in IDLE.
- Accept: req=1 in IDLE. The edge registers we, funct3, a and wd.
  - If LATENCY>0, the FSM goes to WAIT and a counter loads LATENCY-1.
  - Otherwise the FSM goes directly to RESP.
- WAIT: the counter decrements each edge. At 0 the FSM goes to RESP.
- Entering RESP, the memory action executes on that same edge:
  - Store, word: RAM[a[w+1:2]] <= wd, where w = log2(DEPTH).
  - Store, half: the lane pair selected by a[1] gets wd[15:0]. Other bytes are unchanged.
  - Store, byte: the lane selected by a[1:0] gets wd[7:0].
  - Load: the addressed word is read and the lane extracted. B and H are sign-extended; BU and HU are zero-extended. The result is registered into rd.
  - A store also updates rd: rd <= 0.
- RESP lasts one cycle with done=1, then the FSM returns to IDLE.
- Faults, checked at accept:
  - Misaligned: H/HU with a[0]=1, or W with a[1:0]≠0.
  - Illegal funct3: 011, 110 or 111, or a store with 100 or 101.
  - Out of range: a[31:2] ≥ DEPTH.
  - A faulting access follows the same timing but performs no RAM write. It sets rd <= 0 and err=1 with done.
- err is 0 whenever done is 0.
- req while not ready is ignored; the requester must hold req until it sees ready.
- RAM contents are not reset.

## Timing
- Reset values: ready=1, done=0, err=0, rd=32'h0. FSM is in IDLE and the counter is 0.
- Latency: done rises LATENCY+1 cycles after the accept edge.
- Throughput: one access per LATENCY+2 cycles.
- A store is visible to a load accepted after the store's done cycle.
- rst_n asserted mid-access aborts it immediately. A store that has not reached RESP is dropped. A store committed at the RESP edge remains committed.
- rst_n deassertion is synchronised externally. On the first edge after release, ready=1.

## Configuration
- DMEM_LSU_ERR_EN defined:
  - Misalignment, illegal-code and range checks are active as described above.
- DMEM_LSU_ERR_EN undefined:
  - err is tied to 0.
  - Low address bits below the access size are ignored (forced aligned).
  - The word index wraps modulo DEPTH.
  - Illegal funct3 codes are treated as W.
  - The check logic is not synthesised.

## Test plan
- Reset, LATENCY=2: drive rst_n=0 mid-WAIT of a SW -> ready=1, done=0, rd=0; the target word is unchanged.
- SW a=0x10 wd=0x8899AABB, then LB a=0x13 -> rd=0xFFFFFF88; LBU a=0x13 -> rd=0x00000088; LH a=0x12 -> rd=0xFFFF8899; LHU a=0x10 -> rd=0x0000AABB.
- SB a=0x11 wd=0x55, then LW a=0x10 -> rd=0x889955BB. SH a=0x12 wd=0x1234, then LW a=0x10 -> rd=0x123455BB.
- Latency, LATENCY=3: accept at edge N -> done high in cycle N+4, ready low in cycles N+1..N+4, ready high at N+5. A req held through WAIT is not double-accepted.
- With the macro defined: LW a=0x02 -> done with err=1, rd=0. SW a=DEPTH*4 -> err=1 and no word is modified. funct3=011 -> err=1.
- Without the macro, DEPTH=64: SW a=0x101 wd=0xCAFEF00D writes word 0 -> LW a=0x0 returns 0xCAFEF00D with err=0.
